// File: rtl/ram_entrada.sv
// ram_entrada: input-side RAM peripheral serving the CPU's IN operation.
// A read request stalls the CPU until the user sets the switches and presses
// the (active-low) confirm button. The switch value is then stored at the
// latched row/column address, returned on saida, and pronto pulses once.
// The switch and button inputs are synchronized, and the button is debounced.
module ram_entrada #(
  parameter int DATA_W          = 16,
  parameter int ROWS            = 4,
  parameter int COLS            = 4,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic              clock,
  input  logic              resetCPU,
  input  logic              read,
  input  logic [10:0]       end_linha,
  input  logic [10:0]       end_coluna,
  input  logic [DATA_W-1:0] switches,
  input  logic              botao,
  output logic [31:0]       saida,
  output logic              pronto,
  output logic              aguardando
);

  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_PRESS,
    WAIT_RELEASE,
    DONE
  } state_t;

  // Synchronizer stages
  logic              s1_botao_q;
  logic              s2_botao_q;
  logic [DATA_W-1:0] s1_sw_q;
  logic [DATA_W-1:0] s2_sw_q;

  // Debouncer: deb is the accepted button level (1 = released)
  logic              deb_q;
  logic              deb_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;

  // Request state and latched address
  state_t            state_q;
  logic [10:0]       lin_q;
  logic [10:0]       col_q;

  // Input memory
  logic [DATA_W-1:0] mem_q [ROWS][COLS];

  // Address decode for the live (IDLE readback) and latched (capture) address
  logic              rd_in_range;
  logic [ROW_W-1:0]  rd_row;
  logic [COL_W-1:0]  rd_col;
  logic [DATA_W-1:0] rd_data;
  logic              lat_in_range;
  logic [ROW_W-1:0]  lat_row;
  logic [COL_W-1:0]  lat_col;

  // Two-flop synchronizers for the asynchronous board inputs
  always_ff @(posedge clock) begin
    if (resetCPU) begin
      s1_botao_q <= 1'b1;
      s2_botao_q <= 1'b1;
      s1_sw_q    <= '0;
      s2_sw_q    <= '0;
    end else begin
      s1_botao_q <= botao;
      s2_botao_q <= s1_botao_q;
      s1_sw_q    <= switches;
      s2_sw_q    <= s1_sw_q;
    end
  end

  // Debouncer next state: a level change must persist DEBOUNCE_CYCLES edges;
  // any return to the accepted level restarts the count
  always_comb begin
    deb_d = deb_q;
    cnt_d = cnt_q;
    if (s2_botao_q != deb_q) begin
      if (cnt_q == CNT_MAX) begin
        deb_d = s2_botao_q;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      cnt_d = '0;
    end
  end

  // Debouncer registers
  always_ff @(posedge clock) begin
    if (resetCPU) begin
      deb_q <= 1'b1;
      cnt_q <= '0;
    end else begin
      deb_q <= deb_d;
      cnt_q <= cnt_d;
    end
  end

  // Address range checks and memory read mux
  always_comb begin
    rd_in_range  = (32'(end_linha) < ROWS) && (32'(end_coluna) < COLS);
    rd_row       = end_linha[ROW_W-1:0];
    rd_col       = end_coluna[COL_W-1:0];
    rd_data      = '0;
    if (rd_in_range) begin
      rd_data = mem_q[rd_row][rd_col];
    end
    lat_in_range = (32'(lin_q) < ROWS) && (32'(col_q) < COLS);
    lat_row      = lin_q[ROW_W-1:0];
    lat_col      = col_q[COL_W-1:0];
  end

  // Request FSM with registered outputs and the memory write port
  always_ff @(posedge clock) begin
    if (resetCPU) begin
      state_q    <= IDLE;
      lin_q      <= '0;
      col_q      <= '0;
      saida      <= '0;
      pronto     <= 1'b0;
      aguardando <= 1'b0;
      mem_q      <= '{default: '{default: '0}};
    end else begin
      pronto <= 1'b0;
      case (state_q)
        IDLE: begin
          saida <= 32'(rd_data);
          if (read) begin
            lin_q      <= end_linha;
            col_q      <= end_coluna;
            state_q    <= WAIT_PRESS;
            aguardando <= 1'b1;
          end
        end
        WAIT_PRESS: begin
          if (!read) begin
            state_q    <= IDLE;
            aguardando <= 1'b0;
          end else if (!deb_q) begin
            // Out-of-range addresses are still returned, just not stored
            saida <= 32'(s2_sw_q);
            if (lat_in_range) begin
              mem_q[lat_row][lat_col] <= s2_sw_q;
            end
            state_q <= WAIT_RELEASE;
          end
        end
        WAIT_RELEASE: begin
          if (!read) begin
            state_q    <= IDLE;
            aguardando <= 1'b0;
          end else if (deb_q) begin
            state_q    <= DONE;
            aguardando <= 1'b0;
            pronto     <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q    <= IDLE;
          aguardando <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_entrada.sv
// Bench for ram_entrada: directed scenarios with literal expectations plus
// randomized requests, all checked every cycle against a behavioural model.
module tb_ram_entrada;

  localparam int D = 4;

  logic        clock = 1'b0;
  logic        resetCPU;
  logic        read;
  logic [10:0] end_linha;
  logic [10:0] end_coluna;
  logic [15:0] switches;
  logic        botao;
  logic [31:0] saida;
  logic        pronto;
  logic        aguardando;

  int tests = 0;
  int fails = 0;
  int pcount = 0;

  ram_entrada #(
    .DATA_W(16),
    .ROWS(4),
    .COLS(4),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clock(clock),
    .resetCPU(resetCPU),
    .read(read),
    .end_linha(end_linha),
    .end_coluna(end_coluna),
    .switches(switches),
    .botao(botao),
    .saida(saida),
    .pronto(pronto),
    .aguardando(aguardando)
  );

  always #5 clock = ~clock;

  // ---------------- behavioural model ----------------
  bit          m_valid = 0;
  int          m_ph;          // 0 idle, 1 waiting press, 2 waiting release, 3 done
  logic        m_deb;
  int          m_run;         // edges the synced button has disagreed with m_deb
  logic        m_b1, m_b2;
  logic [15:0] m_w1, m_w2;
  logic [15:0] m_mem [4][4];
  int          m_ll, m_lc;
  logic [31:0] e_saida;
  logic        e_pronto, e_ag;

  always @(posedge clock) begin
    if (resetCPU) begin
      m_valid = 1;
      m_ph = 0; m_deb = 1'b1; m_run = 0;
      m_b1 = 1'b1; m_b2 = 1'b1; m_w1 = '0; m_w2 = '0;
      foreach (m_mem[i, j]) m_mem[i][j] = '0;
      m_ll = 0; m_lc = 0;
      e_saida = '0; e_pronto = 1'b0; e_ag = 1'b0;
    end else if (m_valid) begin
      case (m_ph)
        0: begin
          if (int'(end_linha) < 4 && int'(end_coluna) < 4)
            e_saida = {16'h0, m_mem[int'(end_linha)][int'(end_coluna)]};
          else
            e_saida = '0;
          if (read) begin m_ll = int'(end_linha); m_lc = int'(end_coluna); m_ph = 1; end
        end
        1: if (!read) m_ph = 0;
           else if (!m_deb) begin
             e_saida = {16'h0, m_w2};
             if (m_ll < 4 && m_lc < 4) m_mem[m_ll][m_lc] = m_w2;
             m_ph = 2;
           end
        2: if (!read) m_ph = 0; else if (m_deb) m_ph = 3;
        default: m_ph = 0;
      endcase
      e_pronto = (m_ph == 3);
      e_ag     = (m_ph == 1 || m_ph == 2);
      if (m_b2 != m_deb) begin
        m_run++;
        if (m_run == D) begin m_deb = m_b2; m_run = 0; end
      end else m_run = 0;
      m_b2 = m_b1; m_b1 = botao;
      m_w2 = m_w1; m_w1 = switches;
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clock) begin
    if (m_valid) begin
      tests++;
      if (saida !== e_saida || pronto !== e_pronto || aguardando !== e_ag) begin
        fails++;
        $display("FAIL cycle_cmp t=%0t saida=%h exp=%h pronto=%b exp=%b aguardando=%b exp=%b",
                 $time, saida, e_saida, pronto, e_pronto, aguardando, e_ag);
      end
    end
    if (pronto === 1'b1) pcount++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic tick(input int n);
    repeat (n) begin @(posedge clock); #2; end
  endtask

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic wait_pronto(input string nm);
    int k = 0;
    while (pronto !== 1'b1 && k < 60) begin tick(1); k++; end
    tests++;
    if (pronto !== 1'b1) begin
      fails++;
      $display("FAIL %s pronto not seen within 60 cycles got=%b exp=1", nm, pronto);
    end
  endtask

  task automatic set_addr(input int l, input int c);
    end_linha  = 11'(l);
    end_coluna = 11'(c);
  endtask

  task automatic rand_req();
    int l, c, ab, pl;
    l  = $urandom_range(0, 5);
    c  = $urandom_range(0, 5);
    ab = $urandom_range(0, 3);
    pl = $urandom_range(6, 12);
    set_addr(l, c);
    switches = 16'($urandom);
    tick(2);
    read = 1'b1;
    tick(1);
    if ($urandom_range(0, 1) == 1) begin
      repeat ($urandom_range(1, 3)) begin
        botao = 1'b0; tick($urandom_range(1, 3));
        botao = 1'b1; tick($urandom_range(1, 3));
      end
    end
    botao = 1'b0;
    if (ab != 0) begin
      tick(ab * 3);
      read = 1'b0;
      botao = 1'b1;
      tick(8);
    end else begin
      for (int i = 0; i < pl; i++) begin
        if ($urandom_range(0, 9) < 3) switches = 16'($urandom);
        tick(1);
      end
      botao = 1'b1;
      wait_pronto("rand_pronto");
      read = 1'b0;
      tick(1);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int pc0;
    resetCPU = 1'b1; read = 1'b0; botao = 1'b1; switches = '0;
    set_addr(0, 0);
    tick(2);
    check("reset_saida", saida, 32'h0);
    check("reset_pronto", {31'h0, pronto}, 32'h0);
    check("reset_aguardando", {31'h0, aguardando}, 32'h0);
    resetCPU = 1'b0;
    tick(1);

    // Basic IN at (2,1)
    set_addr(2, 1); switches = 16'h00A5; tick(2);
    pc0 = pcount;
    read = 1'b1; tick(1);
    check("req_entry_aguardando", {31'h0, aguardando}, 32'h1);
    botao = 1'b0;
    tick(6);
    check("basic_before_capture", saida, 32'h0);
    tick(1);
    check("basic_capture_P6", saida, 32'h000000A5);
    tick(3);
    botao = 1'b1;
    wait_pronto("basic_pronto");
    read = 1'b0;
    tick(3);
    check("basic_pronto_once", 32'(pcount - pc0), 32'h1);
    check("basic_readback", saida, 32'h000000A5);

    // Reset mid-WAIT_PRESS
    read = 1'b1; tick(2);
    resetCPU = 1'b1; tick(1);
    check("midreset_saida", saida, 32'h0);
    check("midreset_pronto", {31'h0, pronto}, 32'h0);
    check("midreset_aguardando", {31'h0, aguardando}, 32'h0);
    resetCPU = 1'b0; read = 1'b0;
    tick(1);
    check("midreset_mem21", saida, 32'h0);

    // Bounce at (3,3)
    set_addr(3, 3); switches = 16'h5A3C; tick(2);
    pc0 = pcount;
    read = 1'b1; tick(1);
    repeat (3) begin
      botao = 1'b0; tick(2);
      botao = 1'b1; tick(2);
    end
    check("bounce_no_capture", saida, 32'h0);
    check("bounce_still_waiting", {31'h0, aguardando}, 32'h1);
    botao = 1'b0;
    tick(6);
    check("bounce_before_capture", saida, 32'h0);
    tick(1);
    check("bounce_capture", saida, 32'h00005A3C);
    tick(3);
    check("bounce_no_early_pronto", 32'(pcount - pc0), 32'h0);
    botao = 1'b1;
    wait_pronto("bounce_pronto");
    read = 1'b0;
    tick(2);
    check("bounce_pronto_once", 32'(pcount - pc0), 32'h1);

    // Abort during WAIT_PRESS at (0,2)
    set_addr(0, 2); switches = 16'hBEEF; tick(2);
    pc0 = pcount;
    read = 1'b1; tick(3);
    read = 1'b0; tick(1);
    check("abort_aguardando", {31'h0, aguardando}, 32'h0);
    check("abort_no_pronto", 32'(pcount - pc0), 32'h0);
    tick(1);
    check("abort_mem_unchanged", saida, 32'h0);

    // Out-of-range (5,0)
    set_addr(5, 0); switches = 16'h1234; tick(2);
    pc0 = pcount;
    read = 1'b1; tick(1);
    botao = 1'b0; tick(7);
    check("oor_capture", saida, 32'h00001234);
    tick(3);
    botao = 1'b1;
    wait_pronto("oor_pronto");
    read = 1'b0;
    tick(2);
    check("oor_idle_read", saida, 32'h0);
    check("oor_pronto_once", 32'(pcount - pc0), 32'h1);
    set_addr(1, 0); tick(2);
    check("oor_mem10_unchanged", saida, 32'h0);

    // Back-to-back at (1,2)
    set_addr(1, 2); switches = 16'h1111; tick(2);
    read = 1'b1; tick(1);
    botao = 1'b0; tick(10);
    botao = 1'b1;
    wait_pronto("b2b_first_pronto");
    switches = 16'h2222;
    tick(1);
    check("b2b_idle_gap", {31'h0, aguardando}, 32'h0);
    tick(1);
    check("b2b_second_request", {31'h0, aguardando}, 32'h1);
    botao = 1'b0; tick(10);
    botao = 1'b1;
    wait_pronto("b2b_second_pronto");
    read = 1'b0;
    tick(2);
    check("b2b_readback", saida, 32'h00002222);

    // Randomized requests
    for (int n = 0; n < 40; n++) begin
      rand_req();
      set_addr($urandom_range(0, 5), $urandom_range(0, 5));
      tick(2);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
